neuron_acc_ctrl: RTL and testbench
==================================

NEURON_ACC_CTRL -- requirements
Module: neuron_acc_ctrl

Interface
REQ-001 Parameter DW, default 8: width of one sign-magnitude input or weight word (MSB = sign, DW-1 magnitude bits).
REQ-002 Parameter O_VEC, default 21: width of the sign-magnitude accumulator, bias and result (MSB = sign).
REQ-003 Parameter N_IN, default 16: number of input/weight pairs per neuron; legal range 1..1024.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  begin one neuron evaluation; sampled only in IDLE.
REQ-007 bias  in  O_VEC  sign-magnitude bias; loaded into the accumulator on an accepted start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 x_valid  in  1  pair on x_data/w_data is valid.
REQ-010 x_ready  out  1  block accepts a pair this cycle.
REQ-011 x_data, w_data  in  DW each  sign-magnitude input and weight.
REQ-012 y_valid  out  1  result on y_data is valid.
REQ-013 y_ready  in  1  consumer accepts the result.
REQ-014 y_data  out  O_VEC  sign-magnitude neuron sum.
REQ-015 ovf  out  1  saturation occurred during the current or last evaluation.

Function
REQ-016 States: IDLE, ACCUM, DONE; one-hot or binary encoding is free.
REQ-017 IDLE: start=1 -> acc<=bias (negative zero normalised to +0), count<=0, ovf<=0, next state ACCUM; start=0 -> stay.
REQ-018 ACCUM: x_ready=1; a pair is accepted on a cycle with x_valid=1; x_valid=0 -> acc and count hold, no timeout.
REQ-019 Product of an accepted pair: sign = x sign XOR w sign; magnitude = x magnitude * w magnitude, 2*DW-2 bits, zero-extended to O_VEC-1 bits.
REQ-020 Accumulate: equal signs -> magnitudes add, sign kept; unequal signs -> smaller magnitude subtracted from larger, sign of the larger operand; equal magnitudes -> +0.
REQ-021 Any zero-magnitude result is stored with sign 0; negative zero is never stored.
REQ-022 Same-sign magnitude sum exceeding 2^(O_VEC-1)-1 -> magnitude saturates to all ones, sign kept, ovf<=1 (sticky until next accepted start).
REQ-023 The accumulate completes in the acceptance cycle: acc is updated at the same edge that accepts the pair; one pair per cycle at full throughput.
REQ-024 Acceptance of pair number N_IN (count = N_IN-1) -> next state DONE; the final pair is included in acc.
REQ-025 DONE: y_valid=1, y_data=acc, x_ready=0; y_data and ovf stable while y_valid=1 and y_ready=0.
REQ-026 DONE with y_ready=1 -> next state IDLE; y_valid deasserts the following cycle.
REQ-027 Latency: first accepted start to y_valid = N_IN+1 cycles when x_valid is held high.
REQ-028 start is ignored in ACCUM and DONE; start on the cycle DONE exits is ignored; a new evaluation needs start in IDLE.
REQ-029 Outside DONE, y_data holds the last result; outside ACCUM, x_ready=0.

Reset
REQ-030 rst=1 at a clock edge -> state IDLE, acc=0, count=0, y_data=0, y_valid=0, x_ready=0, busy=0, ovf=0, regardless of state, including mid-ACCUM and DONE.
REQ-031 rst has priority over start, x_valid and y_ready on the same edge; no partial result survives reset.

Verification
REQ-032 N_IN=4, bias=+0, x=+3 x4, w={+2,-1,+5,+1}, x_valid held high -> y_valid 5 cycles after start, y_data=+21 (21'h000015), ovf=0.
REQ-033 N_IN=4, bias=+10, products summing to -10 (x=+1, w={-4,-3,-2,-1}) -> y_data=21'h000000 (+0, sign bit 0).
REQ-034 N_IN=4, bias=+(2^20-100), first product +127*+127 -> y_data=21'h0FFFFF, ovf=1; ovf cleared by the next start.
REQ-035 x_valid toggled 1,0,0,1,1,0,1 during ACCUM -> exactly 4 pairs accepted, result identical to REQ-032; y_ready low 5 cycles in DONE -> y_data, y_valid held, x_ready=0.
REQ-036 rst asserted after 2 accepted pairs -> all outputs at reset values next cycle; new start with REQ-032 stimulus -> y_data=+21.
REQ-037 start pulsed in ACCUM and DONE -> no reload of acc, no change in result or count.

Source files
------------

// File: rtl/neuron_acc_ctrl.sv
// -----------------------------------------------------------------------------
// neuron_acc_ctrl
//   Sequential sign-magnitude multiply-accumulate controller for one neuron.
//   A start in IDLE loads the bias into the accumulator. N_IN input/weight
//   pairs are then accepted over a valid/ready handshake, one per cycle at
//   most. Each product is added to the accumulator in the same cycle it is
//   accepted. The sum is presented over a valid/ready result handshake.
//   Same-sign additions that overflow saturate the magnitude and set a
//   sticky ovf flag. ovf stays set until the next accepted start.
//
// Ports
//   clk      in   1      clock; all state changes on its rising edge
//   rst      in   1      synchronous active-high reset
//   start    in   1      begin an evaluation (sampled only in IDLE)
//   bias     in   O_VEC  sign-magnitude bias, loaded on an accepted start
//   busy     out  1      high whenever the block is not idle
//   x_valid  in   1      x_data/w_data pair is valid
//   x_ready  out  1      block accepts a pair this cycle (ACCUM only)
//   x_data   in   DW     sign-magnitude input
//   w_data   in   DW     sign-magnitude weight
//   y_valid  out  1      y_data holds a valid result
//   y_ready  in   1      consumer accepts the result
//   y_data   out  O_VEC  sign-magnitude neuron sum (held after hand-off)
//   ovf      out  1      saturation occurred in the current or last evaluation
// -----------------------------------------------------------------------------
module neuron_acc_ctrl #(
    parameter int DW    = 8,
    parameter int O_VEC = 21,
    parameter int N_IN  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [O_VEC-1:0] bias,
    output logic             busy,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [DW-1:0]    x_data,
    input  logic [DW-1:0]    w_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [O_VEC-1:0] y_data,
    output logic             ovf
);

    // Magnitude width of the accumulator, product width, and counter width.
    localparam int MW = O_VEC - 1;
    localparam int PW = 2 * DW - 2;
    localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [O_VEC-1:0] acc_r;
    logic [CW-1:0]    count_r;

    logic [PW-1:0]    prod_mag_s;
    logic [O_VEC-1:0] prod_sm_s;
    logic [O_VEC-1:0] sum_sm_s;
    logic             sum_ovf_s;
    logic             last_pair_s;

    // Turn a negative zero into +0; all other values pass through.
    function automatic logic [O_VEC-1:0] sm_norm(input logic [O_VEC-1:0] v);
        logic [O_VEC-1:0] r;
        if (v[MW-1:0] == {MW{1'b0}}) begin
            r = {O_VEC{1'b0}};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Sign-magnitude addition. The result is {overflow, sum}. On a same-sign
    // overflow the magnitude saturates to all ones and keeps the sign. For
    // opposite signs, the sign of the larger magnitude wins. Zero is always +0.
    function automatic logic [O_VEC:0] sm_add(input logic [O_VEC-1:0] a,
                                              input logic [O_VEC-1:0] b);
        logic [MW:0]   wide;
        logic [MW-1:0] ma;
        logic [MW-1:0] mb;
        logic [MW-1:0] mr;
        logic          sr;
        logic          of;
        ma   = a[MW-1:0];
        mb   = b[MW-1:0];
        wide = {1'b0, ma} + {1'b0, mb};
        of   = 1'b0;
        if (a[MW] == b[MW]) begin
            sr = a[MW];
            if (wide[MW]) begin
                mr = {MW{1'b1}};
                of = 1'b1;
            end else begin
                mr = wide[MW-1:0];
            end
        end else if (ma > mb) begin
            sr = a[MW];
            mr = ma - mb;
        end else if (mb > ma) begin
            sr = b[MW];
            mr = mb - ma;
        end else begin
            sr = 1'b0;
            mr = {MW{1'b0}};
        end
        if (mr == {MW{1'b0}}) begin
            sr = 1'b0;
        end else begin
            sr = sr;
        end
        return {of, sr, mr};
    endfunction

    // Product of the presented pair and its sum with the accumulator.
    always_comb begin
        prod_mag_s  = PW'(x_data[DW-2:0]) * PW'(w_data[DW-2:0]);
        prod_sm_s   = sm_norm({x_data[DW-1] ^ w_data[DW-1], MW'(prod_mag_s)});
        {sum_ovf_s, sum_sm_s} = sm_add(acc_r, prod_sm_s);
        last_pair_s = (count_r == CW'(N_IN - 1));
    end

    // Control FSM with accumulator, counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= {O_VEC{1'b0}};
            count_r <= {CW{1'b0}};
            y_data  <= {O_VEC{1'b0}};
            y_valid <= 1'b0;
            x_ready <= 1'b0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r   <= sm_norm(bias);
                        count_r <= {CW{1'b0}};
                        ovf     <= 1'b0;
                        x_ready <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= ACCUM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCUM: begin
                    if (x_valid) begin
                        acc_r <= sum_sm_s;
                        if (sum_ovf_s) begin
                            ovf <= 1'b1;
                        end
                        if (last_pair_s) begin
                            // The result register takes the final sum directly, so
                            // y_data equals the accumulator as soon as DONE is entered.
                            y_data  <= sum_sm_s;
                            y_valid <= 1'b1;
                            x_ready <= 1'b0;
                            state_r <= DONE;
                        end else begin
                            count_r <= count_r + CW'(1);
                        end
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                DONE: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    y_valid <= 1'b0;
                    x_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_neuron_acc_ctrl
//   Directed self-checking bench for neuron_acc_ctrl with N_IN=4.
//   Expected sums are computed by hand in sign-magnitude form
//   (bit 20 = sign, bits 19:0 = magnitude).
// -----------------------------------------------------------------------------
module tb_neuron_acc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [20:0] bias;
    logic        busy;
    logic        x_valid;
    logic        x_ready;
    logic [7:0]  x_data;
    logic [7:0]  w_data;
    logic        y_valid;
    logic        y_ready;
    logic [20:0] y_data;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    // Pair tables: pair i sits in bits [8*i +: 8].
    localparam logic [31:0] X_THREE = {8'h03, 8'h03, 8'h03, 8'h03};
    localparam logic [31:0] W_BASIC = {8'h01, 8'h05, 8'h81, 8'h02};
    localparam logic [31:0] X_ONE   = {8'h01, 8'h01, 8'h01, 8'h01};
    localparam logic [31:0] W_NEG   = {8'h81, 8'h82, 8'h83, 8'h84};
    localparam logic [31:0] X_SAT   = {8'h00, 8'h00, 8'h00, 8'h7F};
    localparam logic [31:0] W_SAT   = {8'h00, 8'h00, 8'h00, 8'h7F};
    localparam logic [31:0] X_NEG2  = {8'h82, 8'h82, 8'h82, 8'h82};
    localparam logic [31:0] W_POS3  = {8'h03, 8'h03, 8'h03, 8'h03};

    neuron_acc_ctrl #(.DW(8), .O_VEC(21), .N_IN(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bias    (bias),
        .busy    (busy),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .x_data  (x_data),
        .w_data  (w_data),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_data  (y_data),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Start an evaluation and feed pairs until y_valid or a cycle budget runs out.
    // vpat gives x_valid per ACCUM cycle (bit 0 first). After vlen cycles,
    // x_valid stays high. cyc counts negedges from start to y_valid, or -1.
    task automatic run_eval(input logic [20:0] b, input logic [31:0] xs,
                            input logic [31:0] ws, input logic [15:0] vpat,
                            input int vlen, input bit start_noise, output int cyc);
        int idx  = 0;
        int step = 0;
        bit xr_seen = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        bias    = b;
        x_valid = 1'b0;
        y_ready = 1'b0;
        x_data  = 8'h00;
        w_data  = 8'h00;
        cyc     = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (x_valid && xr_seen) idx++;
            xr_seen = x_ready;
            if (y_valid) begin
                cyc = c;
                break;
            end
            start = start_noise;
            if (xr_seen) begin
                x_valid = (step < vlen) ? vpat[step] : 1'b1;
                step++;
            end else begin
                x_valid = 1'b0;
            end
            x_data = (idx < 4) ? xs[8*idx +: 8] : 8'h00;
            w_data = (idx < 4) ? ws[8*idx +: 8] : 8'h00;
        end
        x_valid = 1'b0;
    endtask

    // Hand the result to the consumer and return to IDLE.
    task automatic release_result();
        start   = 1'b0;
        y_ready = 1'b1;
        @(negedge clk);
        y_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bias = 21'h0; x_valid = 1'b0;
        x_data = 8'h00; w_data = 8'h00; y_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, x_ready, y_valid, ovf} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {busy, x_ready, y_valid, ovf});
        end
        checks++;
        if (y_data !== 21'h000000) begin
            failures++;
            $display("FAIL reset_y_data got=%h exp=000000", y_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_basic();
        int cyc;
        run_eval(21'h000000, X_THREE, W_BASIC, 16'h0, 0, 1'b0, cyc);
        checks++;
        if (cyc !== 5) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=5", cyc);
        end
        checks++;
        if (y_data !== 21'h000015) begin
            failures++;
            $display("FAIL basic_y_data got=%h exp=000015", y_data);
        end
        checks++;
        if ({ovf, x_ready, busy} !== 3'b001) begin
            failures++;
            $display("FAIL basic_flags got=%b exp=001", {ovf, x_ready, busy});
        end
        release_result();
        checks++;
        if ({y_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL basic_release got=%b exp=00", {y_valid, busy});
        end
        checks++;
        if (y_data !== 21'h000015) begin
            failures++;
            $display("FAIL basic_y_hold_idle got=%h exp=000015", y_data);
        end
    endtask

    task automatic test_signs();
        int cyc;
        // +10 -4 -3 -2 -1 = 0, which must be stored as +0.
        run_eval(21'h00000A, X_ONE, W_NEG, 16'h0, 0, 1'b0, cyc);
        checks++;
        if (y_data !== 21'h000000) begin
            failures++;
            $display("FAIL cancel_to_zero got=%h exp=000000", y_data);
        end
        release_result();
        // -5 + 4*(-6) = -29.
        run_eval(21'h100005, X_NEG2, W_POS3, 16'h0, 0, 1'b0, cyc);
        checks++;
        if (y_data !== 21'h10001D) begin
            failures++;
            $display("FAIL negative_sum got=%h exp=10001d", y_data);
        end
        release_result();
        // +10 + 4*(-6) = -14: the sign flips partway through.
        run_eval(21'h00000A, X_NEG2, W_POS3, 16'h0, 0, 1'b0, cyc);
        checks++;
        if (y_data !== 21'h10000E) begin
            failures++;
            $display("FAIL sign_cross got=%h exp=10000e", y_data);
        end
        release_result();
        // A negative-zero bias with all-zero products gives +0.
        run_eval(21'h100000, X_SAT & 32'h0, W_SAT, 16'h0, 0, 1'b0, cyc);
        checks++;
        if (y_data !== 21'h000000) begin
            failures++;
            $display("FAIL neg_zero_bias got=%h exp=000000", y_data);
        end
        release_result();
    endtask

    task automatic test_saturation();
        int cyc;
        // 2^20-100 + 16129 overflows the 20-bit magnitude.
        run_eval(21'h0FFF9C, X_SAT, W_SAT, 16'h0, 0, 1'b0, cyc);
        checks++;
        if (y_data !== 21'h0FFFFF) begin
            failures++;
            $display("FAIL sat_y_data got=%h exp=0fffff", y_data);
        end
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_ovf got=%b exp=1", ovf);
        end
        release_result();
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_ovf_sticky got=%b exp=1", ovf);
        end
        // The next start clears ovf.
        run_eval(21'h000000, X_THREE, W_BASIC, 16'h0, 0, 1'b0, cyc);
        checks++;
        if ({ovf, y_data} !== {1'b0, 21'h000015}) begin
            failures++;
            $display("FAIL sat_ovf_clear got=%b/%h exp=0/000015", ovf, y_data);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int cyc;
        // x_valid pattern 1,0,0,1,1,0,1 accepts 4 pairs over 7 ACCUM cycles.
        run_eval(21'h000000, X_THREE, W_BASIC, 16'b1011001, 7, 1'b0, cyc);
        checks++;
        if (cyc !== 8) begin
            failures++;
            $display("FAIL bp_latency got=%0d exp=8", cyc);
        end
        checks++;
        if (y_data !== 21'h000015) begin
            failures++;
            $display("FAIL bp_y_data got=%h exp=000015", y_data);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({y_valid, x_ready, y_data} !== {2'b10, 21'h000015}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%b%b/%h exp=10/000015",
                         i, y_valid, x_ready, y_data);
            end
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        int cyc;
        @(negedge clk);
        start = 1'b1; bias = 21'h000064;
        @(negedge clk);
        start = 1'b0; x_valid = 1'b1; x_data = 8'h03; w_data = 8'h02;
        @(negedge clk);
        x_data = 8'h03; w_data = 8'h81;
        @(negedge clk);
        // Two pairs accepted; reset wins over every other input this edge.
        rst = 1'b1; start = 1'b1; y_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, x_ready, y_valid, ovf, y_data} !== {4'b0000, 21'h000000}) begin
            failures++;
            $display("FAIL mid_reset got=%b/%h exp=0000/000000",
                     {busy, x_ready, y_valid, ovf}, y_data);
        end
        rst = 1'b0; start = 1'b0; x_valid = 1'b0; y_ready = 1'b0;
        run_eval(21'h000000, X_THREE, W_BASIC, 16'h0, 0, 1'b0, cyc);
        checks++;
        if (y_data !== 21'h000015) begin
            failures++;
            $display("FAIL after_reset_y_data got=%h exp=000015", y_data);
        end
        // Reset while in DONE clears the held result.
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({y_valid, busy, y_data} !== {2'b00, 21'h000000}) begin
            failures++;
            $display("FAIL done_reset got=%b/%h exp=00/000000", {y_valid, busy}, y_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int cyc;
        // start held high through ACCUM must not reload the bias.
        run_eval(21'h000000, X_THREE, W_BASIC, 16'h0, 0, 1'b1, cyc);
        checks++;
        if ({cyc, y_data} !== {32'd5, 21'h000015}) begin
            failures++;
            $display("FAIL start_in_accum got=%0d/%h exp=5/000015", cyc, y_data);
        end
        @(negedge clk);
        checks++;
        if ({y_valid, y_data} !== {1'b1, 21'h000015}) begin
            failures++;
            $display("FAIL start_in_done got=%b/%h exp=1/000015", y_valid, y_data);
        end
        // start is still high on the exit edge, so it must be ignored.
        y_ready = 1'b1;
        @(negedge clk);
        y_ready = 1'b0; start = 1'b0;
        checks++;
        if ({busy, x_ready, y_valid} !== 3'b000) begin
            failures++;
            $display("FAIL start_on_exit got=%b exp=000", {busy, x_ready, y_valid});
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stay_idle got=%b exp=0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
